// File: rtl/regfile_writeback.sv
// Write-back arbiter for the 32x32 register file: one ALU/LSU result per
// cycle onto the write port, plus a pending-write scoreboard for issue.
module regfile_writeback #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            areset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [4:0]      Write_Register,
    output logic [XLEN-1:0] Write_Data,
    output logic            Write_Enable,
    output logic [31:0]     busy
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0]      starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;
    logic [4:0]      wr_rd_q, wr_rd_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            we_q, we_d;

    logic            alu_gnt;
    logic            lsu_gnt;
    logic            xfer;
    logic [4:0]      xfer_rd;
    logic [XLEN-1:0] xfer_data;

    // Grant: LSU wins ties until the ALU has waited STARVE_LIMIT times.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        if (areset) begin
            if (alu_valid && lsu_valid) begin
                alu_gnt = (starve_q == LIMIT);
                lsu_gnt = (starve_q != LIMIT);
            end else begin
                alu_gnt = alu_valid;
                lsu_gnt = lsu_valid;
            end
        end
    end

    assign alu_ready = alu_gnt;
    assign lsu_ready = lsu_gnt;
    assign xfer      = alu_gnt | lsu_gnt;
    assign xfer_rd   = alu_gnt ? alu_rd : lsu_rd;
    assign xfer_data = alu_gnt ? alu_data : lsu_data;

    // Next state for starvation count, write port stage and scoreboard.
    always_comb begin
        starve_d  = starve_q;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        we_d      = 1'b0;
        busy_d    = busy_q;

        if (!alu_valid || alu_gnt) begin
            starve_d = 3'd0;
        end else if (lsu_gnt && starve_q != LIMIT) begin
            starve_d = starve_q + 3'd1;
        end

        if (xfer) begin
            wr_rd_d   = xfer_rd;
            wr_data_d = xfer_data;
            we_d      = (xfer_rd != 5'd0);
            busy_d[xfer_rd] = 1'b0;
        end

        // A new producer for the same register outranks the retiring one.
        if (issue_valid && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any write not yet presented.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            starve_q  <= 3'd0;
            busy_q    <= 32'd0;
            wr_rd_q   <= 5'd0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
        end else begin
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            we_q      <= we_d;
        end
    end

    assign Write_Register = wr_rd_q;
    assign Write_Data     = wr_data_q;
    assign Write_Enable   = we_q;
    assign busy           = busy_q;

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side companion to the 32x32 register file: arbitrates completed results from the ALU and the load/store unit onto the register file's single write port, one write per cycle. It also keeps a pending-write scoreboard so issue logic can stall on unfinished destinations. It sits between the execute/memory stages and the register file write port (`Write_Register` / `Write_Data` / `Write_Enable`).

## Interface

Parameters:
- `XLEN`, 32, data width.
- `STARVE_LIMIT`, 3, maximum consecutive LSU grants while the ALU waits (range 1..7).

Ports:
- `clk`  in  1  rising-edge clock.
- `areset`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result offered.
- `alu_rd`  in  5  ALU destination register.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `lsu_valid`  in  1  load result offered.
- `lsu_rd`  in  5  load destination register.
- `lsu_data`  in  XLEN  load result.
- `lsu_ready`  out  1  load result accepted this cycle.
- `issue_valid`  in  1  an instruction with a destination is issued.
- `issue_rd`  in  5  issued destination; marks it busy.
- `Write_Register`  out  5  register file write address.
- `Write_Data`  out  XLEN  register file write data.
- `Write_Enable`  out  1  register file write strobe.
- `busy`  out  32  scoreboard; bit n=1 means a write to xn is outstanding.

## Operation

- Valid/ready handshake per source. Transfer = valid & ready. A source holds valid/rd/data stable until transfer. Ready depends only on the valids and internal state, never on ready, so there is no combinational loop.
- At most one grant per cycle:
  - One source valid: that source is granted.
  - Both valid: LSU is granted, unless `starve_cnt == STARVE_LIMIT`; then ALU is granted.
- `starve_cnt` (3-bit) updates each edge:
  - +1, saturating at STARVE_LIMIT, when LSU is granted while `alu_valid`.
  - Cleared to 0 on an ALU grant, or on any cycle with `alu_valid` = 0.
- Output stage, registered:
  - On transfer: next cycle `Write_Register` = rd, `Write_Data` = data, `Write_Enable` = (rd != 0).
  - No transfer: `Write_Enable` = 0; `Write_Register` and `Write_Data` hold their last values.
- x0 handling: a transfer with rd = 0 is accepted and consumed, but never asserts `Write_Enable`.
- Scoreboard update at each edge:
  - Set `busy[issue_rd]` if `issue_valid` & `issue_rd` != 0.
  - Clear `busy[rd]` of the transfer if a transfer occurs.
  - If set and clear target the same rd on the same edge, set wins (new producer).
  - `busy[0]` is constant 0.
- The block does not check that a transfer's rd was busy; a clear of a non-busy bit is a no-op.
- `alu_ready` and `lsu_ready` are forced to 0 while `areset` = 0.

## Timing

- Reset (async, on `areset` falling, held while low):
  - `Write_Enable` = 0, `Write_Register` = 0, `Write_Data` = 0.
  - `busy` = 0, `starve_cnt` = 0, both readies = 0.
- Reset mid-operation discards any registered but unperformed write. Sources must re-offer after reset.
- Ready is combinational in the same cycle as valid.
- Latency: transfer at edge N → `Write_Enable` high during cycle N..N+1 → register file captures at edge N+1.
- The busy bit clears at edge N, one edge before the register file holds the value. Issue logic must forward from `Write_*` during that cycle or stall one extra cycle.
- Throughput: one write per cycle, sustained; back-to-back transfers produce back-to-back `Write_Enable` pulses.

## Test plan

- **Reset:** drive continuous transfers, then pull `areset` low between edges → `Write_Enable`, `Write_Register`, `Write_Data`, `busy`, and both readies go to 0 immediately, without waiting for a clock edge. After release, the first grant follows LSU priority with `starve_cnt` = 0.
- **Single ALU write:** `issue_rd` = 5, then `alu_valid` with rd = 5, data = 0xDEADBEEF → `alu_ready` = 1 in the same cycle. Next cycle `Write_Enable` = 1, `Write_Register` = 5, `Write_Data` = 0xDEADBEEF. `busy[5]` goes 1 → 0.
- **Starvation guard:** both sources valid every cycle, STARVE_LIMIT = 3 → grant sequence L, L, L, A, L, L, L, A. Each LSU cycle has `alu_ready` = 0.
- **x0 write:** `lsu_valid` with rd = 0, data = 0x12345678 → `lsu_ready` = 1, next cycle `Write_Enable` = 0, `busy` unchanged.
- **Set/clear collision:** `busy[7]` = 1; on the same edge, an LSU transfer with rd = 7 and `issue_valid`/`issue_rd` = 7 → `busy[7]` = 1 after the edge. A following ALU transfer with rd = 7 clears it.
- **Back-to-back:** ALU-only transfers with rd = 1..4 on four consecutive cycles → four consecutive `Write_Enable` cycles with `Write_Register` = 1, 2, 3, 4 and the matching data.
